mips_multicycle_ctrl: RTL and testbench

- Moore-style control FSM for the multicycle MIPS datapath.
- It is the initiator side of the ALU control interface. It drives alu_op, the ALU operand-source selects, and the register-file and memory enables, and it consumes the ALU ZERO flag.
- It sequences fetch, decode, execute, memory and writeback for the R-type, lw, sw, beq, addi and j instructions.
- Memory accesses use a ready handshake, so wait states are supported.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/mips_ctrl_decode.sv | 90 +++++++++
 rtl/mips_multicycle_ctrl.sv | 101 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path:
// state codes, opcodes, datapath select encodings and the Moore control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_SEXT   = 2'b10;
  localparam logic [1:0] ALUSRCB_SEXT_2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // rdy_gate marks states whose ir_write/pc_write/instr_done only take
  // effect in the cycle the memory reports completion.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
    logic       rdy_gate;
  } ctrl_word_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure state-to-control-word map; everything here depends on the state alone.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t     i_state,
  output ctrl_word_t o_cw
);

  // NOTE: o_cw gets a full default before the case, so every path assigns
  // every field and no latch can be inferred.
  always_comb begin
    o_cw = '0;
    case (i_state)
      S_FETCH: begin
        o_cw.mem_read   = 1'b1;
        o_cw.iord       = 1'b0;
        o_cw.alu_src_a  = 1'b0;
        o_cw.alu_src_b  = ALUSRCB_FOUR;
        o_cw.alu_op     = ALUOP_ADD;
        o_cw.pc_src     = PCSRC_ALU;
        o_cw.ir_write   = 1'b1;
        o_cw.pc_write   = 1'b1;
        o_cw.rdy_gate   = 1'b1;
      end
      S_DECODE: begin
        o_cw.alu_src_a  = 1'b0;
        o_cw.alu_src_b  = ALUSRCB_SEXT_2;
        o_cw.alu_op     = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        o_cw.alu_src_a  = 1'b1;
        o_cw.alu_src_b  = ALUSRCB_SEXT;
        o_cw.alu_op     = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_cw.mem_read   = 1'b1;
        o_cw.iord       = 1'b1;
      end
      S_MEM_WB: begin
        o_cw.reg_write  = 1'b1;
        o_cw.reg_dst    = 1'b0;
        o_cw.mem_to_reg = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        o_cw.mem_write  = 1'b1;
        o_cw.iord       = 1'b1;
        o_cw.instr_done = 1'b1;
        o_cw.rdy_gate   = 1'b1;
      end
      S_EXECUTE: begin
        o_cw.alu_src_a  = 1'b1;
        o_cw.alu_src_b  = ALUSRCB_REGB;
        o_cw.alu_op     = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        o_cw.reg_write  = 1'b1;
        o_cw.reg_dst    = 1'b1;
        o_cw.mem_to_reg = 1'b0;
        o_cw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_cw.alu_src_a  = 1'b1;
        o_cw.alu_src_b  = ALUSRCB_REGB;
        o_cw.alu_op     = ALUOP_SUB;
        o_cw.branch     = 1'b1;
        o_cw.pc_src     = PCSRC_ALUOUT;
        o_cw.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        o_cw.alu_src_a  = 1'b1;
        o_cw.alu_src_b  = ALUSRCB_SEXT;
        o_cw.alu_op     = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        o_cw.reg_write  = 1'b1;
        o_cw.reg_dst    = 1'b0;
        o_cw.mem_to_reg = 1'b0;
        o_cw.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_cw.pc_write   = 1'b1;
        o_cw.pc_src     = PCSRC_JUMP;
        o_cw.instr_done = 1'b1;
      end
      default: o_cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic, and the
// mem_ready / zero / opcode qualification of the Moore control word.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  ctrl_word_t w_cw;
  logic       w_gate;
  logic       w_pc_write;
  logic       w_illegal;

  // NOTE: state is updated with <= so every reader in this edge sees the old
  // value; reset is sampled on the clock edge, not asynchronously.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:      w_next = S_FETCH;
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next = S_MEM_READ;
        else if (opcode == OP_SW) w_next = S_MEM_WRITE;
        else                      w_next = S_FETCH;
      end
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ADDI_WB:   w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      default:     w_next = S_IDLE;
    endcase
  end

  mips_ctrl_decode u_decode (
    .i_state (r_state),
    .o_cw    (w_cw)
  );

  // Memory-side strobes fire only once the access actually completes.
  assign w_gate     = ~w_cw.rdy_gate | mem_ready;
  assign w_pc_write = w_cw.pc_write & w_gate;
  assign w_illegal  = (r_state == S_DECODE) && !is_supported(opcode);

  assign pc_en      = w_pc_write | (w_cw.branch & zero);
  assign iord       = w_cw.iord;
  assign mem_read   = w_cw.mem_read;
  assign mem_write  = w_cw.mem_write;
  assign ir_write   = w_cw.ir_write & w_gate;
  assign reg_dst    = w_cw.reg_dst;
  assign mem_to_reg = w_cw.mem_to_reg;
  assign reg_write  = w_cw.reg_write;
  assign alu_src_a  = w_cw.alu_src_a;
  assign alu_src_b  = w_cw.alu_src_b;
  assign alu_op     = w_cw.alu_op;
  assign pc_src     = w_cw.pc_src;
  assign instr_done = (w_cw.instr_done & w_gate) | w_illegal;
  assign illegal_op = w_illegal;
  assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: each instruction is expanded into its expected state
// path (with random wait states) and every cycle is compared to a spec table.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       instr_done, illegal_op;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  function automatic logic legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected outputs for a given spec state number and the current inputs.
  function automatic obs_t exp_out(input logic [3:0] st, input logic rdy,
                                   input logic z, input logic [5:0] op);
    obs_t e;
    e = '0;
    e.state = st;
    case (st)
      4'd1:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
      4'd2:  begin
        e.alu_src_b = 2'b11;
        if (!legal(op)) begin e.illegal_op = 1; e.instr_done = 1; end
      end
      4'd3:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd4:  begin e.mem_read = 1; e.iord = 1; end
      4'd5:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      4'd6:  begin e.mem_write = 1; e.iord = 1; e.instr_done = rdy; end
      4'd7:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      4'd8:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      4'd9:  begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.pc_en = z; e.instr_done = 1;
      end
      4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd11: begin e.reg_write = 1; e.instr_done = 1; end
      4'd12: begin e.pc_en = 1; e.pc_src = 2'b10; e.instr_done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state = state;       o.pc_en = pc_en;           o.iord = iord;
    o.mem_read = mem_read; o.mem_write = mem_write;   o.ir_write = ir_write;
    o.reg_dst = reg_dst;   o.mem_to_reg = mem_to_reg; o.reg_write = reg_write;
    o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.alu_op = alu_op;
    o.pc_src = pc_src;     o.instr_done = instr_done; o.illegal_op = illegal_op;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare mid-cycle, then advance.
  task automatic step(input logic [3:0] st, input logic rdy, input int zsel);
    mem_ready = rdy;
    zero = (zsel < 0) ? rb() : 1'(zsel);
    #1;
    check($sformatf("st%0d op%b rdy%b z%b rst%b", st, opcode, rdy, zero, reset),
          sample(), exp_out(st, rdy, zero, opcode));
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its expected FETCH..last-state path.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int zsel);
    opcode = op;
    for (int i = 0; i < fw; i++) step(4'd1, 1'b0, zsel);
    step(4'd1, 1'b1, zsel);
    step(4'd2, rb(), zsel);
    case (op)
      OP_LW: begin
        step(4'd3, rb(), zsel);
        for (int i = 0; i < mw; i++) step(4'd4, 1'b0, zsel);
        step(4'd4, 1'b1, zsel);
        step(4'd5, rb(), zsel);
      end
      OP_SW: begin
        step(4'd3, rb(), zsel);
        for (int i = 0; i < mw; i++) step(4'd6, 1'b0, zsel);
        step(4'd6, 1'b1, zsel);
      end
      OP_RTYPE: begin step(4'd7, rb(), zsel); step(4'd8, rb(), zsel); end
      OP_BEQ:   step(4'd9, rb(), zsel);
      OP_ADDI:  begin step(4'd10, rb(), zsel); step(4'd11, rb(), zsel); end
      OP_J:     step(4'd12, rb(), zsel);
      default:  ;
    endcase
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops[0] = OP_RTYPE; ops[1] = OP_LW;   ops[2] = OP_SW;
    ops[3] = OP_BEQ;   ops[4] = OP_ADDI; ops[5] = OP_J;

    reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(4'd0, rb(), -1);
    reset = 1'b0;
    step(4'd0, rb(), -1);

    run_instr(OP_LW, 0, 0, -1);
    run_instr(OP_SW, 0, 2, -1);
    run_instr(OP_BEQ, 0, 0, 1);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(OP_RTYPE, 1, 0, -1);
    run_instr(OP_ADDI, 0, 0, -1);
    run_instr(OP_J, 2, 0, -1);
    run_instr(OP_LW, 1, 3, -1);

    opcode = OP_SW;
    step(4'd1, 1'b1, -1);
    step(4'd2, rb(), -1);
    step(4'd3, rb(), -1);
    step(4'd6, 1'b0, -1);
    reset = 1'b1;
    step(4'd6, 1'b0, -1);
    step(4'd0, 1'b0, -1);
    step(4'd0, 1'b1, -1);
    reset = 1'b0;
    step(4'd0, rb(), -1);

    opcode = OP_LW;
    step(4'd1, 1'b1, -1);
    step(4'd2, rb(), -1);
    step(4'd3, rb(), -1);
    reset = 1'b1;
    step(4'd4, 1'b1, -1);
    step(4'd0, 1'b1, -1);
    reset = 1'b0;
    step(4'd0, rb(), -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, rb() ? 0 : int'($urandom_range(1, 3)),
                rb() ? 0 : int'($urandom_range(1, 3)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
